// File: rtl/systolic_skew_feeder.sv
// Edge operand injector for an NxN PE mesh: buffers one K-deep tile,
// then streams it with lane i delayed by i cycles, zero-padded elsewhere.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int K_MAX      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);

    localparam int W     = N * DATA_WIDTH;
    localparam int CW    = $clog2(K_MAX + N);
    localparam int AW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_KMAX = CW'(K_MAX);
    localparam logic [CW-1:0] C_KM1  = CW'(K_MAX - 1);
    localparam logic [CW-1:0] C_NM1  = CW'(N - 1);

    logic [1:0]    r_state;
    logic [W-1:0]  r_buf [DEPTH];
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_k;
    logic [CW-1:0] r_t;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_done;
    logic          r_ovf;

    logic          w_acc;
    logic [AW-1:0] w_waddr;
    logic [CW-1:0] w_t_end;
    logic [W-1:0]  w_lanes;

    assign in_ready  = !rst && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_acc     = in_valid && in_ready;
    assign w_waddr   = (r_state == S_IDLE) ? '0 : r_wr_cnt[AW-1:0];
    assign w_t_end   = r_k + C_NM1 - C_ONE;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign ovf       = r_ovf;

    // Lane i shows slice (t-i) of its own column while that slice exists.
    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < N; i++) begin
            if (r_t >= CW'(i) && (r_t - CW'(i)) < r_k) begin
                w_lanes[i*DATA_WIDTH +: DATA_WIDTH] =
                    r_buf[AW'(r_t - CW'(i))][i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[w_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_cnt    <= '0;
            r_k         <= '0;
            r_t         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    if (w_acc) begin
                        r_wr_cnt <= C_ONE;
                        r_ovf    <= 1'b0;
                        if (in_last || K_MAX == 1) begin
                            r_k     <= C_ONE;
                            r_ovf   <= !in_last;
                            r_state <= S_STREAM;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_acc) begin
                        r_wr_cnt <= r_wr_cnt + C_ONE;
                        if (in_last) begin
                            r_k     <= r_wr_cnt + C_ONE;
                            r_state <= S_STREAM;
                        end else if (r_wr_cnt == C_KM1) begin
                            r_k     <= C_KMAX;
                            r_ovf   <= 1'b1;
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_lanes;
                    if (r_t == w_t_end) begin
                        r_state <= S_DONE;
                    end else begin
                        r_t <= r_t + C_ONE;
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_done      <= 1'b1;
                    r_t         <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed + randomized bench for systolic_skew_feeder against a
// per-lane delay-line reference model.
module tb_systolic_skew_feeder;

    localparam int DW    = 8;
    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int W     = N * DW;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] tile_q[$];
    logic [W-1:0] exp_q[$];

    systolic_skew_feeder #(
        .DATA_WIDTH(DW),
        .N(N),
        .K_MAX(K_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_data(out_data),
        .out_valid(out_valid),
        .busy(busy),
        .done(done),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each lane is its tile column behind i leading zeros,
    // padded with trailing zeros to K+N-1 beats.
    task automatic build_model();
        int k;
        int len;
        logic [DW-1:0] lane[$];
        k   = tile_q.size();
        len = k + N - 1;
        exp_q = {};
        for (int j = 0; j < len; j++) exp_q.push_back('0);
        for (int i = 0; i < N; i++) begin
            lane = {};
            for (int z = 0; z < i; z++) lane.push_back('0);
            foreach (tile_q[b]) lane.push_back(tile_q[b][i*DW +: DW]);
            while (lane.size() < len) lane.push_back('0);
            for (int j = 0; j < len; j++) exp_q[j][i*DW +: DW] = lane[j];
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [W-1:0] d, input logic last,
                        input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 200), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        check("load_out_zero", {31'd0, out_valid, out_data}, 64'd0);
    endtask

    // Entered one negedge after the final accept; leaves on the done cycle.
    task automatic collect(input logic exp_ovf);
        check("pre_stream_valid", 64'(out_valid), 64'd0);
        check("ovf", 64'(ovf), 64'(exp_ovf));
        @(negedge clk);
        foreach (exp_q[j]) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(exp_q[j]));
            check("stream_ready", 64'(in_ready), 64'd0);
            check("stream_busy", 64'(busy), 64'd1);
            check("stream_done", 64'(done), 64'd0);
            @(negedge clk);
        end
        check("done_pulse", 64'(done), 64'd1);
        check("done_valid", 64'(out_valid), 64'd0);
        check("done_data", 64'(out_data), 64'd0);
        check("done_ovf", 64'(ovf), 64'(exp_ovf));
    endtask

    task automatic load_tile(input int gap_max);
        foreach (tile_q[b]) begin
            push(tile_q[b], b == tile_q.size() - 1,
                 (gap_max > 0) ? int'($urandom_range(gap_max)) : 0);
        end
        build_model();
    endtask

    logic [W-1:0] held;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_outs", {59'd0, out_valid, busy, done, ovf, |out_data},
              64'd0);
        @(negedge clk);
        check("idle_ready", 64'(in_ready), 64'd1);

        // K=4 directed tile: lane i, beat k = 10i+k+1
        tile_q = {};
        for (int k = 0; k < 4; k++)
            tile_q.push_back({8'(31 + k), 8'(21 + k), 8'(11 + k), 8'(1 + k)});
        load_tile(0);
        check("k4_len", 64'(exp_q.size()), 64'd7);
        check("k4_lane3_b3", 64'(exp_q[3][31:24]), 64'd31);
        collect(1'b0);

        // K=1 single beat
        tile_q = {};
        tile_q.push_back({8'd8, 8'd7, 8'd6, 8'd5});
        load_tile(0);
        collect(1'b0);

        // Stall pattern 1,0,0,1,1(last)
        tile_q = {};
        for (int k = 0; k < 3; k++) tile_q.push_back(W'($urandom));
        push(tile_q[0], 1'b0, 0);
        push(tile_q[1], 1'b0, 2);
        push(tile_q[2], 1'b1, 0);
        build_model();
        collect(1'b0);

        // Overflow: 17 beats, no last; beat 17 waits for the next tile
        tile_q = {};
        for (int k = 0; k < K_MAX; k++) tile_q.push_back(W'($urandom));
        foreach (tile_q[b]) push(tile_q[b], 1'b0, 0);
        build_model();
        held     = W'($urandom);
        in_valid = 1'b1;
        in_data  = held;
        in_last  = 1'b1;
        collect(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        check("ovf_next_done", 64'(done), 64'd0);
        tile_q = {};
        tile_q.push_back(held);
        build_model();
        collect(1'b0);

        // Reset during stream cycle 2 of a K=4 tile
        tile_q = {};
        for (int k = 0; k < 4; k++) tile_q.push_back(W'($urandom));
        load_tile(0);
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outs", {59'd0, out_valid, busy, done, ovf, |out_data},
              64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_nodone", 64'(done), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        tile_q = {};
        for (int k = 0; k < 4; k++) tile_q.push_back(W'($urandom));
        load_tile(1);
        collect(1'b0);

        // Random tiles with random stalls
        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(K_MAX, 1));
            tile_q = {};
            for (int b = 0; b < k; b++) tile_q.push_back(W'($urandom));
            load_tile(2);
            collect(1'b0);
        end

        @(negedge clk);
        check("end_done_low", 64'(done), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Edge operand injector for the NxN accumulate-only PE grid; drives one edge, either the west inputs (A rows) or the north inputs (B columns), with the diagonal skew the mesh requires.
- Buffers one K-deep operand tile, then streams it so lane i is delayed by i cycles.
- Pads every non-data slot with zeros, so downstream PEs only ever accumulate defined values.
- One instance per array edge, between the tile buffer/DMA and the mesh.

Parameters:
DATA_WIDTH, 8, width of one operand element
N, 4, number of lanes (array rows or columns)
K_MAX, 16, maximum tile depth (beats) stored; power of two not required

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  upstream beat valid
in_ready  out  1  feeder can accept a beat
in_data  in  N*DATA_WIDTH  one k-slice; lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
in_last  in  1  marks final beat of tile
out_data  out  N*DATA_WIDTH  skewed lane values to the mesh edge, registered
out_valid  out  1  stream cycle active
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the final stream beat
ovf  out  1  sticky: tile was truncated at K_MAX; cleared on next accepted first beat or rst

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, all outputs 0 (in_ready=0 during rst cycle, 1 after), counters 0, ovf=0. Buffer contents are don't-care. rst mid-LOAD/STREAM aborts immediately; out_data=0 and no done pulse.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: in_ready=1, out_data=0, out_valid=0.
  - Accepted beat (in_valid&in_ready) is written to buf[0], wr_cnt=1, ovf cleared.
  - If in_last=1, go to STREAM with K=1; else go to LOAD.
- LOAD: in_ready=1. Each accepted beat is written to buf[wr_cnt], and wr_cnt increments.
  - Beat with in_last=1: K=wr_cnt+1, go to STREAM.
  - Accepted beat filling index K_MAX-1 without in_last: K=K_MAX, ovf=1, go to STREAM. Any later upstream beats wait; in_ready=0.
  - in_valid low stalls with no state change.
- STREAM: in_ready=0. Stream counter t runs 0..K+N-2, one step per cycle, and no backpressure exists.
  - Registered output, 1 cycle after t: out_valid=1.
  - Lane i = buf[t-i][i] when 0 <= t-i < K, else 0.
  - Exactly K+N-1 consecutive out_valid cycles.
  - After the cycle with t=K+N-2, go to DONE.
- DONE: one cycle. done=1 on the cycle after the last out_valid=1 cycle, out_data=0. Go to IDLE; in_ready is 1 the following cycle.
- Latency: the first accepted beat to out_valid is at least 2 cycles (for K=1, accept at cycle c gives out_valid at c+2). Total tile occupancy = K load beats + K+N-1 stream + 1 done.
- Outside out_valid, out_data is held at all-zero, never X.
- Widths: counters sized clog2(K_MAX+N). No arithmetic on data; values pass through unmodified.
- Simultaneous events: in_valid during STREAM/DONE is ignored (in_ready=0). rst has priority over all.

Test Plan:
- N=4, K=4, A row i = {10i+1, 10i+2, 10i+3, 10i+4} loaded as k-slices, last on beat 4 -> 7 out_valid cycles.
  - Lane0 = 1,2,3,4,0,0,0.
  - Lane3 = 0,0,0,31,32,33,34.
  - done pulses one cycle after the 7th beat.
- K=1 single beat {5,6,7,8} with in_last -> out_valid for 4 cycles; lane i is nonzero only at stream cycle i; done follows; in_ready=0 from the accept+1 cycle until IDLE.
- Stall: in_valid toggles 1,0,0,1,1(last) -> K=3 stored in order, stream identical to an unstalled load.
- Overflow: 17 beats with no in_last, K_MAX=16 -> K=16, ovf=1; the 17th beat is held (in_ready=0) and accepted as the first beat of the next tile, which clears ovf.
- rst asserted at stream cycle 2 of a K=4 tile -> next cycle out_valid=0, out_data=0, busy=0, no done; a fresh tile afterwards streams correctly.
- Feed into a 4x4 pe mesh with identity B -> accumulated results equal A, and no PE ever sees a non-zero value outside valid slots.
